// File: rtl/vc_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : vc_fifo
//  Description : Multi-virtual-channel input buffer for a NoC router port.
//                NUM_VC independent circular queues share one storage array.
//                Each VC has its own pointers, occupancy count, flags and
//                credit-return pulse. Read data is registered (1-cycle latency).
//                Optional sticky overflow/underflow error outputs are built
//                when the macro VC_FIFO_ERR_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
module vc_fifo #(
  parameter int DATA_WIDTH = 33,
  parameter int NUM_VC     = 4,
  parameter int VC_DEPTH   = 8,
  parameter int AF_THRESH  = 2,
  localparam int VW        = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
  localparam int CW        = $clog2(VC_DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [VW-1:0]          wr_vc,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  input  logic                   rd_en,
  input  logic [VW-1:0]          rd_vc,
  output logic [DATA_WIDTH-1:0]  rd_data,
  output logic                   rd_valid,
  output logic [NUM_VC-1:0]      full,
  output logic [NUM_VC-1:0]      empty,
  output logic [NUM_VC-1:0]      almost_full,
  output logic [NUM_VC-1:0]      almost_empty,
  output logic [NUM_VC*CW-1:0]   count,
  output logic [NUM_VC-1:0]      credit_out
`ifdef VC_FIFO_ERR_EN
  ,
  output logic [NUM_VC-1:0]      err_overflow,
  output logic [NUM_VC-1:0]      err_underflow
`endif
);

  // Pointer layout: AW index bits plus one wrap bit.
  localparam int AW      = $clog2(VC_DEPTH);
  localparam int PW      = AW + 1;
  localparam int ENTRIES = NUM_VC * VC_DEPTH;
  localparam int LW      = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  // Elaboration-time parameter sanity checks.
  if (NUM_VC < 1) begin : g_bad_num_vc
    $error("vc_fifo: NUM_VC must be >= 1");
  end
  if ((VC_DEPTH < 2) || ((VC_DEPTH & (VC_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("vc_fifo: VC_DEPTH must be a power of two and >= 2");
  end
  if ((AF_THRESH < 0) || (AF_THRESH >= VC_DEPTH)) begin : g_bad_af
    $error("vc_fifo: AF_THRESH must be in [0, VC_DEPTH)");
  end

  // Shared flit storage; VC v owns entries [v*VC_DEPTH, v*VC_DEPTH+VC_DEPTH).
  logic [DATA_WIDTH-1:0] mem [ENTRIES];

  // Per-VC pointers.
  logic [PW-1:0] wr_ptr_q [NUM_VC];
  logic [PW-1:0] wr_ptr_d [NUM_VC];
  logic [PW-1:0] rd_ptr_q [NUM_VC];
  logic [PW-1:0] rd_ptr_d [NUM_VC];

  // Registered read side.
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [NUM_VC-1:0]     credit_q, credit_d;

  // Request decode.
  logic [NUM_VC-1:0] wr_hit, rd_hit;
  logic [AW-1:0]     wr_lo, rd_lo;
  logic [LW-1:0]     wr_addr, rd_addr;
  logic              wr_accept, rd_accept;

  // Per-VC status flags derived from the pointer pair.
  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc_flags
    logic [PW-1:0] occ;
    assign occ             = wr_ptr_q[v] - rd_ptr_q[v];
    assign empty[v]        = (wr_ptr_q[v] == rd_ptr_q[v]);
    assign full[v]         = (wr_ptr_q[v][AW-1:0] == rd_ptr_q[v][AW-1:0]) &&
                             (wr_ptr_q[v][AW] != rd_ptr_q[v][AW]);
    assign almost_full[v]  = (occ >= PW'(VC_DEPTH - AF_THRESH));
    assign almost_empty[v] = (occ == PW'(1));
    assign count[v*CW +: CW] = CW'(occ);
  end

  // Decode the addressed VC of each request, its pointer index bits and the
  // shared-storage address; out-of-range VC numbers never hit.
  always_comb begin
    wr_hit = '0;
    rd_hit = '0;
    wr_lo  = '0;
    rd_lo  = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      if (wr_vc == VW'(v)) begin
        wr_hit[v] = 1'b1;
        wr_lo     = wr_ptr_q[v][AW-1:0];
      end
      if (rd_vc == VW'(v)) begin
        rd_hit[v] = 1'b1;
        rd_lo     = rd_ptr_q[v][AW-1:0];
      end
    end
    wr_accept = wr_en && |(wr_hit & ~full);
    rd_accept = rd_en && |(rd_hit & ~empty);
    wr_addr   = LW'(int'(wr_vc) * VC_DEPTH + int'(wr_lo));
    rd_addr   = LW'(int'(rd_vc) * VC_DEPTH + int'(rd_lo));
  end

  // Next-state for pointers and the registered read port; accept decisions use
  // pre-edge flags so a full VC still drains and an empty VC still fills.
  always_comb begin
    for (int v = 0; v < NUM_VC; v++) begin
      wr_ptr_d[v] = wr_ptr_q[v];
      rd_ptr_d[v] = rd_ptr_q[v];
    end
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    credit_d   = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      if (wr_accept && wr_hit[v]) begin
        wr_ptr_d[v] = wr_ptr_q[v] + PW'(1);
      end
      if (rd_accept && rd_hit[v]) begin
        rd_ptr_d[v] = rd_ptr_q[v] + PW'(1);
        credit_d[v] = 1'b1;
      end
    end
    if (rd_accept) begin
      rd_data_d  = mem[rd_addr];
      rd_valid_d = 1'b1;
    end
  end

  // Control state with asynchronous reset; storage is deliberately not reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int v = 0; v < NUM_VC; v++) begin
        wr_ptr_q[v] <= '0;
        rd_ptr_q[v] <= '0;
      end
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      credit_q   <= '0;
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        wr_ptr_q[v] <= wr_ptr_d[v];
        rd_ptr_q[v] <= rd_ptr_d[v];
      end
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      credit_q   <= credit_d;
    end
  end

  // Storage write port.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign credit_out = credit_q;

`ifdef VC_FIFO_ERR_EN
  logic [NUM_VC-1:0] err_ov_q, err_ov_d;
  logic [NUM_VC-1:0] err_un_q, err_un_d;

  // Sticky error bits: any request aimed at a VC that cannot serve it.
  always_comb begin
    err_ov_d = err_ov_q;
    err_un_d = err_un_q;
    if (wr_en) begin
      err_ov_d = err_ov_q | (wr_hit & full);
    end
    if (rd_en) begin
      err_un_d = err_un_q | (rd_hit & empty);
    end
  end

  // Error registers, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_ov_q <= '0;
      err_un_q <= '0;
    end else begin
      err_ov_q <= err_ov_d;
      err_un_q <= err_un_d;
    end
  end

  assign err_overflow  = err_ov_q;
  assign err_underflow = err_un_q;
`endif

endmodule
`default_nettype wire

// File: doc/vc_fifo.md
Name: vc_fifo

Overview:
Multi-virtual-channel input buffer for a NoC router port, generalising the single-queue FIFO to NUM_VC independent circular queues held in one shared storage array. Each VC has its own pointers, occupancy count, full/empty/almost-full flags and credit-return pulse. It sits between link receive logic (write side) and the VC/switch allocator (read side). Read data is registered, with one-cycle latency.

Parameters:
DATA_WIDTH, 33, flit width in bits.
NUM_VC, 4, number of virtual channels; must be >= 1.
VC_DEPTH, 8, entries per VC; must be a power of two and >= 2.
AF_THRESH, 2, almost_full asserts when free slots in a VC are <= AF_THRESH; must be < VC_DEPTH.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
wr_en  input  1  write request.
wr_vc  input  $clog2(NUM_VC) (min 1)  target VC of the write.
wr_data  input  DATA_WIDTH  flit to write.
rd_en  input  1  read request.
rd_vc  input  $clog2(NUM_VC) (min 1)  source VC of the read.
rd_data  output  DATA_WIDTH  registered read data.
rd_valid  output  1  high for one cycle when rd_data holds a newly read flit.
full  output  NUM_VC  per-VC full.
empty  output  NUM_VC  per-VC empty.
almost_full  output  NUM_VC  per-VC free slots <= AF_THRESH.
almost_empty  output  NUM_VC  per-VC count == 1.
count  output  NUM_VC*$clog2(VC_DEPTH+1)  packed per-VC occupancy; VC v occupies slice [v*CW +: CW].
credit_out  output  NUM_VC  one-cycle pulse per flit dequeued, returned upstream.

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous and active-low.
- Reset values: all wr/rd pointers 0, count 0, empty all 1s, full/almost_full/almost_empty all 0s, rd_data 0, rd_valid 0, credit_out 0. Storage contents are not reset.
- Storage: NUM_VC*VC_DEPTH entries. The entry address is vc*VC_DEPTH + ptr[log2(VC_DEPTH)-1:0].
- Pointers: each pointer is log2(VC_DEPTH)+1 bits wide, with the extra bit as the wrap bit. Pointers wrap naturally modulo 2*VC_DEPTH.
- empty[v] = (wr_ptr[v] == rd_ptr[v]).
- full[v] = low bits equal and wrap bits differ.
- Write acceptance: a write is accepted iff wr_en && !full[wr_vc], evaluated on pre-edge state. On the edge, mem is written and wr_ptr[wr_vc] increments. A write to a full VC is dropped with no state change.
- Read acceptance: a read is accepted iff rd_en && !empty[rd_vc], evaluated on pre-edge state. On the edge:
  - rd_data <= mem[entry];
  - rd_ptr[rd_vc] increments;
  - rd_valid <= 1;
  - credit_out[rd_vc] <= 1.
  A read of an empty VC is dropped: rd_valid <= 0 and rd_data holds its previous value.
- Latency: rd_data/rd_valid/credit_out are valid the cycle after the accepted rd_en. No bypass path: a write to an empty VC is readable (empty deasserts) one cycle after the write edge.
- Simultaneous read and write, same VC: both are accepted if their individual conditions hold, and count is unchanged.
  - Full VC: the read proceeds and the write is dropped.
  - Empty VC: the write proceeds and the read is dropped.
- Simultaneous read and write, different VCs: fully independent.
- count[v] = wr_ptr[v] - rd_ptr[v], computed modulo 2*VC_DEPTH. Flags are derived combinationally from pointers/count.
- credit_out: at most one bit is set per cycle.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). In-flight rd_valid and credit pulses are discarded.

Optional Feature:
- Macro: VC_FIFO_ERR_EN.
- When defined, two extra output ports are present:
  - err_overflow (NUM_VC): sticky; bit v sets on wr_en with wr_vc==v while full[v].
  - err_underflow (NUM_VC): sticky; bit v sets on rd_en with rd_vc==v while empty[v].
  - Both are cleared only by reset. Their behaviour is otherwise identical.
- When undefined, these ports and their logic are absent, and illegal requests are silently dropped.

Test Plan:
- Reset then idle -> empty=4'b1111, full=0, count all 0, rd_valid=0, rd_data=0, credit_out=0.
- Write 8 flits 0x0..0x7 to VC2:
  - full[2]=1 after the 8th edge;
  - almost_full[2]=1 once count[2]>=6;
  - a 9th write (0x1FF) is dropped and count stays 8.
  - Read 8 flits -> rd_data 0x0..0x7 in order, each one cycle after rd_en, with credit_out[2] pulsing 8 times.
- Interleave writes to VC0 (0xA0..) and VC3 (0xB0..), then read VC3 then VC0 -> each VC returns only its own data in FIFO order, with no cross-VC corruption.
- VC1 holding 3 flits, simultaneous write+read to VC1 for 10 cycles -> count[1] stays 3 throughout, and pointers wrap past 8 with correct data order.
- Read of empty VC0 -> rd_valid=0, rd_data unchanged, credit_out=0. With VC_FIFO_ERR_EN defined -> err_underflow[0]=1 and it stays set until reset.
- Assert rst_n=0 mid-stream while VC2 holds 5 flits and a read is pending -> all outputs return to reset values asynchronously, and the pending rd_valid/credit pulse never appears.
